// File: rtl/udp_len_pkg.sv
// Shared types for the UDP length meter: default length width, length
// record layout and stage-2 packet FSM states.
package udp_len_pkg;

    localparam int unsigned LEN_W_DEF = 16;

    // Length record as seen by the downstream header builder
    typedef struct packed {
        logic                 err;
        logic [LEN_W_DEF-1:0] len;
    } len_rec_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } len_state_e;

endpackage

// File: rtl/keep_popcount.sv
// keep_popcount: byte count of a tkeep vector, one popcount8 per keep byte
// followed by a summation of the per-byte counts. Purely combinational.
// Ports: keep (KEEP_W byte enables), cnt_c (number of enabled bytes).
module keep_popcount #(
    parameter int unsigned KEEP_W = 64,
    parameter int unsigned CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  cnt_c
);

    localparam int unsigned LANES = KEEP_W / 8;

    logic [3:0] lane_cnt [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        popcount8 u_pc8 (
            .en      (1'b1),
            .in_bits (keep[g*8 +: 8]),
            .cnt_c   (lane_cnt[g])
        );
    end

    // Sum of lane counts; synthesis balances this into a tree
    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt_c = cnt_c + CNT_W'(lane_cnt[i]);
        end
    end

endmodule

// File: rtl/popcount8.sv
// popcount8: number of set bits in one byte, gated by en.
// Ports: en (enable, count forced to 0 when low), in_bits (byte),
//        cnt_c (combinational count 0..8).
module popcount8 (
    input  logic       en,
    input  logic [7:0] in_bits,
    output logic [3:0] cnt_c
);

    always_comb begin
        cnt_c = '0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                cnt_c = cnt_c + 4'(in_bits[i]);
            end
        end
    end

endmodule

// File: rtl/udp_len_meter.sv
// udp_len_meter: passive AXI4-Stream tap measuring packet byte lengths.
// Stage 1 registers popcount(tkeep) for each accepted beat; stage 2
// accumulates with saturation and pushes one {err,len} record per packet
// into a first-word-fall-through FIFO read through a valid/ready port.
// Ports: clk, rst (async, active high); s_axis_* observed stream (inputs
// only); m_len_valid/ready/data/err record output; pkt_cnt, drop_cnt stats.
// Build option: UDP_LEN_METER_STATS_EN builds the pkt_cnt/drop_cnt counters;
// without it both are tied to 0.
module udp_len_meter
    import udp_len_pkg::*;
#(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned KEEP_W     = DATA_W / 8,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tready,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              m_len_valid,
    input  logic              m_len_ready,
    output logic [LEN_W-1:0]  m_len_data,
    output logic              m_len_err,
    output logic [31:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned CNT_W  = $clog2(KEEP_W + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned REC_W  = LEN_W + 1;

    // ---------------- stage 1: per-beat byte count ----------------
    logic [CNT_W-1:0] keep_cnt_c;
    logic             beat_q, beat_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;

    keep_popcount #(.KEEP_W(KEEP_W), .CNT_W(CNT_W)) u_keep_popcount (
        .keep  (s_axis_tkeep),
        .cnt_c (keep_cnt_c)
    );

    always_comb begin
        beat_d  = s_axis_tvalid & s_axis_tready;
        last_d  = beat_d & s_axis_tlast;
        bytes_d = beat_d ? keep_cnt_c : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= 1'b0;
            last_q  <= 1'b0;
            bytes_q <= '0;
        end else begin
            beat_q  <= beat_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
        end
    end

    // ---------------- stage 2: accumulate and enqueue ----------------
    len_state_e       state_q, state_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [LEN_W:0]   sum_c;
    logic [LEN_W-1:0] len_sat_c;
    logic             sat_new_c;
    logic             push_c, push_ok_c, pop_c;

    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [REC_W-1:0] wr_rec_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sat_d     = sat_q;

        // Saturating add at LEN_W+1 bits; the carry flags overflow
        sum_c     = {1'b0, acc_q} + (LEN_W + 1)'(bytes_q);
        len_sat_c = sum_c[LEN_W] ? '1 : sum_c[LEN_W-1:0];
        sat_new_c = sat_q | sum_c[LEN_W];
        wr_rec_d  = {sat_new_c, len_sat_c};

        pop_c     = valid_q & m_len_ready;
        push_c    = beat_q & last_q;
        // A same-cycle pop frees the slot the push needs
        push_ok_c = push_c & ((count_q != OCC_W'(FIFO_DEPTH)) | pop_c);

        if (beat_q) begin
            if (last_q) begin
                state_d = IDLE;
                acc_d   = '0;
                sat_d   = 1'b0;
            end else begin
                state_d = IN_PKT;
                acc_d   = len_sat_c;
                sat_d   = sat_new_c;
            end
        end

        wr_ptr_d = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + OCC_W'(push_ok_c) - OCC_W'(pop_c);
        valid_d  = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= wr_rec_d;
            end
        end
    end

    // FWFT head; stays stable until popped
    assign m_len_valid = valid_q;
    assign m_len_data  = mem_q[rd_ptr_q][LEN_W-1:0];
    assign m_len_err   = mem_q[rd_ptr_q][LEN_W];

    // ---------------- statistics ----------------
`ifdef UDP_LEN_METER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + 32'(push_c);
        drop_cnt_d = drop_cnt_q;
        if (push_c && !push_ok_c && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_len_meter.sv
// Directed bench for udp_len_meter: latency, byte counting, saturation,
// FIFO overflow/drop, push-with-pop on a full FIFO and mid-packet reset.
module tb_udp_len_meter;

    localparam int unsigned KEEP_W = 64;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast;
    logic              m_len_valid;
    logic              m_len_ready;
    logic [LEN_W-1:0]  m_len_data;
    logic              m_len_err;
    logic [31:0]       pkt_cnt;
    logic [15:0]       drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_pkt  = 0;
    int exp_drop = 0;

    localparam logic [KEEP_W-1:0] FULL = '1;

    udp_len_meter #(
        .DATA_W     (512),
        .KEEP_W     (KEEP_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_len_valid   (m_len_valid),
        .m_len_ready   (m_len_ready),
        .m_len_data    (m_len_data),
        .m_len_err     (m_len_err),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Statistics are only present when the counters are built
    function automatic logic [31:0] st(input int v);
`ifdef UDP_LEN_METER_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    function automatic logic [KEEP_W-1:0] keep_n(input int n);
        logic [KEEP_W-1:0] one;
        one = KEEP_W'(1);
        if (n >= KEEP_W) return FULL;
        return (one << n) - one;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat, driven at a falling edge
    task automatic beat(input logic [KEEP_W-1:0] keep, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] len, input logic err);
        check({tag, "_valid"}, 32'(m_len_valid), 32'd1);
        check({tag, "_len"},   32'(m_len_data),  32'(len));
        check({tag, "_err"},   32'(m_len_err),   32'(err));
        m_len_ready = 1'b1;
        @(negedge clk);
        m_len_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_len_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(m_len_valid), 32'd0);
        check("rst_data",  32'(m_len_data),  32'd0);
        check("rst_err",   32'(m_len_err),   32'd0);
        check("rst_pkt",   pkt_cnt,          32'd0);
        check("rst_drop",  32'(drop_cnt),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single full last beat: record visible two cycles later
        beat(FULL, 1'b1);
        exp_pkt++;
        check("lat_n1_valid", 32'(m_len_valid), 32'd0);
        @(negedge clk);
        check("t1_pkt", pkt_cnt, st(exp_pkt));
        pop_chk("t1", 16'd64, 1'b0);
        check("t1_empty", 32'(m_len_valid), 32'd0);

        // full, full, 0x0F
        beat(FULL, 1'b0);
        beat(FULL, 1'b0);
        beat(keep_n(4), 1'b1);
        exp_pkt++;
        @(negedge clk);
        pop_chk("t2", 16'd132, 1'b0);

        // full, zero-keep, (stalled non-beat), full, 0x0F
        beat(FULL, 1'b0);
        beat('0, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b0;
        s_axis_tkeep  = FULL;
        s_axis_tlast  = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        beat(FULL, 1'b0);
        beat(keep_n(4), 1'b1);
        exp_pkt++;
        @(negedge clk);
        pop_chk("t2b", 16'd132, 1'b0);

        // Saturation: 1025*64 + 1 > 0xFFFF
        for (int i = 0; i < 1025; i++) beat(FULL, 1'b0);
        beat(keep_n(1), 1'b1);
        exp_pkt++;
        @(negedge clk);
        pop_chk("sat", 16'hFFFF, 1'b1);
        beat(FULL, 1'b1);
        exp_pkt++;
        @(negedge clk);
        pop_chk("after_sat", 16'd64, 1'b0);

        // Overflow: five packets of 1..5 bytes, depth 4, consumer stalled
        for (int n = 1; n <= 5; n++) begin
            beat(keep_n(n), 1'b1);
            exp_pkt++;
        end
        exp_drop = 1;
        repeat (2) @(negedge clk);
        check("ovf_pkt",  pkt_cnt,       st(exp_pkt));
        check("ovf_drop", 32'(drop_cnt), st(exp_drop));
        pop_chk("ovf1", 16'd1, 1'b0);
        pop_chk("ovf2", 16'd2, 1'b0);
        pop_chk("ovf3", 16'd3, 1'b0);
        pop_chk("ovf4", 16'd4, 1'b0);
        check("ovf_empty", 32'(m_len_valid), 32'd0);

        // Full FIFO with push coinciding with pop: no drop
        for (int n = 8; n <= 11; n++) begin
            beat(keep_n(n), 1'b1);
            exp_pkt++;
        end
        repeat (2) @(negedge clk);
        beat(keep_n(12), 1'b1);
        exp_pkt++;
        check("pp_head", 32'(m_len_data), 32'd8);
        m_len_ready = 1'b1;
        @(negedge clk);
        m_len_ready = 1'b0;
        check("pp_drop", 32'(drop_cnt), st(exp_drop));
        check("pp_pkt",  pkt_cnt,       st(exp_pkt));
        pop_chk("pp9",  16'd9,  1'b0);
        pop_chk("pp10", 16'd10, 1'b0);
        pop_chk("pp11", 16'd11, 1'b0);
        pop_chk("pp12", 16'd12, 1'b0);
        check("pp_empty", 32'(m_len_valid), 32'd0);

        // Reset mid-packet discards the partial packet
        beat(FULL, 1'b0);
        beat(FULL, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pkt  = 0;
        exp_drop = 0;
        check("mid_rst_valid", 32'(m_len_valid), 32'd0);
        beat(keep_n(2), 1'b1);
        exp_pkt++;
        @(negedge clk);
        check("mid_rst_pkt",  pkt_cnt,       st(exp_pkt));
        check("mid_rst_drop", 32'(drop_cnt), st(exp_drop));
        pop_chk("mid_rst", 16'd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
